adc_period_meter: RTL and testbench
===================================

# adc_period_meter

Consumes the 12-bit offset-binary sample stream from the AD9226 capture stage and measures the period of the input waveform in `sys_clk` cycles. It squares the signal with a hysteresis comparator around a programmable threshold, then times consecutive rising crossings. It averages 2^AVG_LOG2 periods per result and flags loss of signal. The averaged period feeds the downstream frequency-division and display logic.

## Interface
Parameters:
- `DATA_W`, 12, sample width; samples are offset binary, 0..4095 maps to -10 V..+10 V.
- `CNT_W`, 32, width of the period counter and of `o_period`.
- `HYST`, 64, hysteresis half-width in LSB.
- `AVG_LOG2`, 2, log2 of the number of periods averaged per result.
- `TIMEOUT`, 26_000_000, cycles without a rising crossing before no-signal is declared. Must be < 2^CNT_W − 1.

Ports:
- `sys_clk`, in, 1, system clock. All logic runs on it.
- `sys_rst`, in, 1, asynchronous, active-high reset.
- `i_sample_valid`, in, 1, one-cycle strobe per new ADC sample, already in the `sys_clk` domain.
- `i_sample`, in, DATA_W, ADC sample, qualified by `i_sample_valid`.
- `i_thresh`, in, DATA_W, comparator centre; sampled every valid cycle.
- `o_square`, out, 1, registered comparator output.
- `o_period`, out, CNT_W, averaged period in `sys_clk` cycles.
- `o_period_valid`, out, 1, one-cycle pulse when `o_period` updates.
- `o_no_signal`, out, 1, high while no valid periodic input is present.

## Operation
- Reset values:
  - `o_square`=0, `o_period`=0, `o_period_valid`=0, `o_no_signal`=1.
  - FSM in S_IDLE; the counter, accumulator and period index are all 0.
- Comparator thresholds:
  - TH_HI = min(i_thresh+HYST, 2^DATA_W−1).
  - TH_LO = max(i_thresh−HYST, 0).
  - Compute both at DATA_W+1 bits, then saturate.
- Comparator update, evaluated only on `i_sample_valid`:
  - If `o_square`=0 and `i_sample` ≥ TH_HI, set it to 1.
  - If `o_square`=1 and `i_sample` ≤ TH_LO, set it to 0.
  - Otherwise hold.
- Rising edge: a cycle where `o_square` is 1 and its previous-cycle value was 0.
- Period counter:
  - Increments every cycle and saturates at 2^CNT_W−1.
  - On a rising edge, the captured period is the number of cycles since the previous rising edge. The counter restarts so that edges at cycles t0 and t1 give a period of t1−t0.
- FSM:
  - **S_IDLE** → S_ARM on a rising edge. The counter restarts and nothing is captured.
  - **S_ARM** → S_ACC on the next rising edge. The first period is added to the accumulator and the index is set to 1.
  - **S_ACC**: each rising edge adds the period to the accumulator and increments the index.
    - When the index reaches 2^AVG_LOG2, set `o_period` = acc >> AVG_LOG2 (truncating).
    - Pulse `o_period_valid` and clear the accumulator and index.
    - Stay in S_ACC.
  - Any state except S_IDLE: if the counter reaches TIMEOUT with no edge, go to S_IDLE.
    - Set `o_no_signal`=1 and discard the accumulator and index.
    - `o_period` holds its last value.
- Accumulator width is CNT_W+AVG_LOG2, so it cannot overflow.
- `o_no_signal` clears in the same cycle as the first `o_period_valid` after S_IDLE, not on the first edge.
- Simultaneous events:
  - A rising edge in the same cycle the counter reaches TIMEOUT counts as an edge; no timeout occurs.
  - Changing `i_thresh` mid-run takes effect on the next valid sample.

## Timing
- Comparator: `o_square` updates on the clock edge that samples `i_sample_valid`=1, so one cycle of latency.
- Edge-to-result: `o_period_valid` and the new `o_period` appear one cycle after the rising-edge cycle that completes the 2^AVG_LOG2-th period.
- First result after reset or timeout: requires 2^AVG_LOG2+1 rising edges.
- Reset:
  - `sys_rst` asserted at any time returns all outputs to their reset values immediately, without waiting for a clock.
  - After release, operation resumes from S_IDLE on the next clock.
- Throughput: back-to-back `i_sample_valid` on every cycle is supported.

## Test plan
- **Square input**: valid every 4 cycles; 10 samples at 0 and 10 samples at 4095, repeating; i_thresh=2048, defaults.
  - The period is 80 cycles.
  - The first `o_period_valid` comes 1 cycle after the 5th rising edge, with `o_period`=80 and `o_no_signal`→0.
  - A pulse then follows every 320 cycles.
- **Hysteresis**: samples alternate 2048+63 and 2048−63, i_thresh=2048.
  - `o_square` stays 0 and `o_period_valid` never asserts.
  - Changing the samples to 2112 and 1984 makes `o_square` toggle each sample.
- **Threshold saturation**: i_thresh=4090, samples alternate 4095 and 0.
  - TH_HI saturates to 4095, the output toggles, and the measured period is correct.
- **Averaging truncation**: alternate periods of 80 and 81 cycles.
  - Sum 322, so `o_period`=80.
- **Timeout**: TIMEOUT=1000; stop the input mid-accumulation after 2 periods.
  - At 1000 cycles after the last edge, `o_no_signal`=1 and `o_period` holds 80.
  - On restart, the next result needs 5 edges and is not contaminated by the pre-timeout periods.
- **Reset mid-operation**: assert `sys_rst` for 3 cycles between edges in S_ACC.
  - All outputs return to reset values asynchronously.
  - After release, the first `o_period_valid` follows the 5th new rising edge.

Source files
------------

// File: rtl/adc_period_meter.sv
// Hysteresis comparator on an ADC sample stream, then averaged rising-edge period
// measurement in sys_clk cycles with loss-of-signal detection.
//
// state  | meaning
// S_IDLE | no reference edge yet; waiting for the first rising crossing
// S_ARM  | one edge seen; the next edge yields the first full period
// S_ACC  | accumulating periods; every 2^AVG_LOG2 periods publishes a result
module adc_period_meter #(
  parameter int DATA_W   = 12,
  parameter int CNT_W    = 32,
  parameter int HYST     = 64,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 26_000_000
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              i_sample_valid,
  input  logic [DATA_W-1:0] i_sample,
  input  logic [DATA_W-1:0] i_thresh,
  output logic              o_square,
  output logic [CNT_W-1:0]  o_period,
  output logic              o_period_valid,
  output logic              o_no_signal
);

  localparam int ACC_W = CNT_W + AVG_LOG2;
  localparam int IDX_W = AVG_LOG2 + 1;
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(1 << AVG_LOG2);
  localparam logic [DATA_W:0]   HYST_X    = (DATA_W + 1)'(HYST);
  localparam logic [DATA_W:0]   FULL_X    = (DATA_W + 1)'((1 << DATA_W) - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_ACC} state_t;

  state_t             state_q, state_d;
  logic               sq_q, sq_d;
  logic               sq_prev_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic               valid_q, valid_d;
  logic               nosig_q, nosig_d;

  logic [DATA_W:0]    th_hi_x, th_lo_x;
  logic [DATA_W-1:0]  th_hi, th_lo;
  logic               rise, tmo;
  logic [ACC_W-1:0]   acc_sum;
  logic [IDX_W-1:0]   idx_inc;

  // Thresholds are formed one bit wider so both ends can saturate cleanly.
  always_comb begin
    th_hi_x = {1'b0, i_thresh} + HYST_X;
    th_lo_x = {1'b0, i_thresh} - HYST_X;
    th_hi   = (th_hi_x > FULL_X) ? FULL_X[DATA_W-1:0] : th_hi_x[DATA_W-1:0];
    th_lo   = th_lo_x[DATA_W] ? '0 : th_lo_x[DATA_W-1:0];
  end

  always_comb begin
    sq_d = sq_q;
    if (i_sample_valid) begin
      if (!sq_q && (i_sample >= th_hi)) begin
        sq_d = 1'b1;
      end else if (sq_q && (i_sample <= th_lo)) begin
        sq_d = 1'b0;
      end
    end
  end

  // An edge in the terminal-count cycle wins over the timeout.
  assign rise = sq_q & ~sq_prev_q;
  assign tmo  = (state_q != S_IDLE) && !rise && (cnt_q == TIMEOUT_C);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (rise) state_d = S_ARM;
      S_ARM:   if (rise) state_d = S_ACC; else if (tmo) state_d = S_IDLE;
      S_ACC:   if (tmo)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    acc_d    = acc_q;
    idx_d    = idx_q;
    period_d = period_q;
    valid_d  = 1'b0;
    nosig_d  = nosig_q;
    acc_sum  = ((state_q == S_ARM) ? '0 : acc_q) + ACC_W'(cnt_q);
    idx_inc  = ((state_q == S_ARM) ? '0 : idx_q) + IDX_W'(1);
    if (rise) begin
      cnt_d = CNT_W'(1);
    end
    if (tmo) begin
      acc_d   = '0;
      idx_d   = '0;
      nosig_d = 1'b1;
    end else if (rise && (state_q != S_IDLE)) begin
      if (idx_inc == IDX_LAST) begin
        period_d = CNT_W'(acc_sum >> AVG_LOG2);
        valid_d  = 1'b1;
        nosig_d  = 1'b0;
        acc_d    = '0;
        idx_d    = '0;
      end else begin
        acc_d = acc_sum;
        idx_d = idx_inc;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sq_q      <= 1'b0;
      sq_prev_q <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      nosig_q   <= 1'b1;
    end else begin
      sq_q      <= sq_d;
      sq_prev_q <= sq_q;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      nosig_q   <= nosig_d;
    end
  end

  assign o_square       = sq_q;
  assign o_period       = period_q;
  assign o_period_valid = valid_q;
  assign o_no_signal    = nosig_q;

endmodule

// File: tb/tb_adc_period_meter.sv
// Directed bench for adc_period_meter: expected periods are queued as stimulus is
// driven and consumed by a monitor whenever o_period_valid pulses.
`timescale 1ns/1ps
module tb_adc_period_meter;

  localparam int DATA_W   = 12;
  localparam int CNT_W    = 32;
  localparam int AVG_LOG2 = 2;
  localparam int TIMEOUT  = 1000;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic              i_sample_valid = 1'b0;
  logic [DATA_W-1:0] i_sample = '0;
  logic [DATA_W-1:0] i_thresh = 12'd2048;
  logic              o_square;
  logic [CNT_W-1:0]  o_period;
  logic              o_period_valid;
  logic              o_no_signal;

  adc_period_meter #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .HYST(64), .AVG_LOG2(AVG_LOG2), .TIMEOUT(TIMEOUT)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .i_sample_valid(i_sample_valid),
    .i_sample(i_sample), .i_thresh(i_thresh), .o_square(o_square),
    .o_period(o_period), .o_period_valid(o_period_valid), .o_no_signal(o_no_signal)
  );

  always #5 sys_clk = ~sys_clk;

  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  int unsigned exp_q[$];
  int          rise_q[$];
  int          vt_q[$];
  logic        sq_prev = 1'b0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Monitor: stamps rising edges and result pulses, scores each result.
  always @(negedge sys_clk) begin
    if (o_period_valid === 1'b1) begin
      vt_q.push_back(cyc);
      n_vec++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_valid: observed period %0d expected no pulse", o_period);
      end
      if (exp_q.size() != 0) chk("period", 64'(o_period), 64'(exp_q.pop_front()));
      chk("nosig_at_valid", 64'(o_no_signal), 64'd0);
    end
    if (o_square === 1'b1 && sq_prev === 1'b0) rise_q.push_back(cyc);
    sq_prev = o_square;
  end

  task automatic samp(input logic [DATA_W-1:0] v, input int gap);
    i_sample_valid = 1'b1;
    i_sample = v;
    @(posedge sys_clk); #1;
    i_sample_valid = 1'b0;
    repeat (gap - 1) begin @(posedge sys_clk); #1; end
  endtask

  // 10 low then 10 high samples every 4 cycles; extra stretches the high half.
  task automatic wave(input logic [DATA_W-1:0] lo, input logic [DATA_W-1:0] hi, input int extra);
    repeat (10) samp(lo, 4);
    repeat (9) samp(hi, 4);
    samp(hi, 4 + extra);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge sys_clk); #1; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, r1, r2, v1, v2, t_last, t_ns;
    logic found;

    #12;
    chk("rst_square", 64'(o_square), 64'd0);
    chk("rst_period", 64'(o_period), 64'd0);
    chk("rst_valid", 64'(o_period_valid), 64'd0);
    chk("rst_nosig", 64'(o_no_signal), 64'd1);
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    idle(2);

    // Hysteresis: just inside the band never switches, just on it toggles.
    i_thresh = 12'd2048;
    repeat (10) begin samp(12'd2111, 4); samp(12'd1985, 4); end
    chk("hyst_square", 64'(o_square), 64'd0);
    chk("hyst_rises", 64'(rise_q.size()), 64'd0);
    repeat (3) begin
      samp(12'd2112, 4);
      chk("hyst_hi", 64'(o_square), 64'd1);
      samp(12'd1984, 4);
      chk("hyst_lo", 64'(o_square), 64'd0);
    end
    idle(1100);
    chk("hyst_nosig", 64'(o_no_signal), 64'd1);
    chk("hyst_no_valid", 64'(vt_q.size()), 64'd0);

    // Square input, period 80.
    r0 = rise_q.size();
    repeat (3) exp_q.push_back(80);
    repeat (4) wave(12'd0, 12'd4095, 0);
    chk("sq_nosig_before", 64'(o_no_signal), 64'd1);
    chk("sq_no_early_valid", 64'(vt_q.size()), 64'd0);
    repeat (9) wave(12'd0, 12'd4095, 0);
    chk("sq_results", 64'(vt_q.size()), 64'd3);
    if (vt_q.size() >= 3 && rise_q.size() > r0 + 4) begin
      chk("sq_first_latency", 64'(vt_q[0] - rise_q[r0 + 4]), 64'd1);
      chk("sq_interval1", 64'(vt_q[1] - vt_q[0]), 64'd320);
      chk("sq_interval2", 64'(vt_q[2] - vt_q[1]), 64'd320);
    end
    chk("sq_nosig_after", 64'(o_no_signal), 64'd0);

    // Averaging: 80+83+83+83=329 -> 82, then 81+80+81+80=322 -> 80.
    exp_q.push_back(82);
    wave(12'd0, 12'd4095, 3);
    wave(12'd0, 12'd4095, 3);
    wave(12'd0, 12'd4095, 3);
    wave(12'd0, 12'd4095, 1);
    exp_q.push_back(80);
    wave(12'd0, 12'd4095, 0);
    wave(12'd0, 12'd4095, 1);
    wave(12'd0, 12'd4095, 0);
    wave(12'd0, 12'd4095, 1);
    chk("avg_drained", 64'(exp_q.size()), 64'd0);
    chk("avg_period", 64'(o_period), 64'd80);

    // Timeout after two accumulated periods (81, 80).
    wave(12'd0, 12'd4095, 0);
    wave(12'd0, 12'd4095, 0);
    t_last = (rise_q.size() > 0) ? rise_q[rise_q.size() - 1] : 0;
    found = 1'b0;
    t_ns = 0;
    for (int i = 0; i < 1500 && !found; i++) begin
      @(negedge sys_clk);
      if (o_no_signal === 1'b1) begin found = 1'b1; t_ns = cyc; end
    end
    chk("tmo_seen", 64'(found), 64'd1);
    chk("tmo_delay", 64'(t_ns - t_last), 64'd1001);
    chk("tmo_period_hold", 64'(o_period), 64'd80);
    @(posedge sys_clk); #1;

    // Restart: five fresh edges, periods of 85 only.
    r1 = rise_q.size();
    v1 = vt_q.size();
    exp_q.push_back(85);
    repeat (4) wave(12'd0, 12'd4095, 5);
    chk("restart_no_early", 64'(vt_q.size()), 64'(v1));
    wave(12'd0, 12'd4095, 0);
    if (vt_q.size() > v1 && rise_q.size() > r1 + 4)
      chk("restart_latency", 64'(vt_q[v1] - rise_q[r1 + 4]), 64'd1);
    chk("restart_drained", 64'(exp_q.size()), 64'd0);

    // Threshold saturation: TH_HI clamps to 4095, period 10.
    idle(1100);
    chk("sat_pre_nosig", 64'(o_no_signal), 64'd1);
    chk("sat_pre_hold", 64'(o_period), 64'd85);
    i_thresh = 12'd4090;
    exp_q.push_back(10);
    exp_q.push_back(10);
    samp(12'd0, 5);
    chk("sat_lo", 64'(o_square), 64'd0);
    samp(12'd4095, 5);
    chk("sat_hi", 64'(o_square), 64'd1);
    repeat (8) begin samp(12'd0, 5); samp(12'd4095, 5); end
    chk("sat_drained", 64'(exp_q.size()), 64'd0);
    chk("sat_period", 64'(o_period), 64'd10);

    // Reset between edges while accumulating.
    i_thresh = 12'd2048;
    wave(12'd0, 12'd4095, 0);
    wave(12'd0, 12'd4095, 0);
    repeat (10) samp(12'd0, 4);
    repeat (5) samp(12'd4095, 4);
    sys_rst = 1'b1;
    #1;
    chk("arst_square", 64'(o_square), 64'd0);
    chk("arst_period", 64'(o_period), 64'd0);
    chk("arst_valid", 64'(o_period_valid), 64'd0);
    chk("arst_nosig", 64'(o_no_signal), 64'd1);
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    r2 = rise_q.size();
    v2 = vt_q.size();
    exp_q.push_back(82);
    repeat (4) wave(12'd0, 12'd4095, 2);
    chk("arst_no_early", 64'(vt_q.size()), 64'(v2));
    wave(12'd0, 12'd4095, 0);
    if (vt_q.size() > v2 && rise_q.size() > r2 + 4)
      chk("arst_latency", 64'(vt_q[v2] - rise_q[r2 + 4]), 64'd1);

    idle(5);
    chk("all_drained", 64'(exp_q.size()), 64'd0);
    chk("total_results", 64'(vt_q.size()), 64'd9);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
